// File: rtl/sprite_line_eval_if.sv
// Sprite evaluator bus: line/window inputs, sprite RAM read port and slot results.
interface sprite_line_eval_if #(
  parameter int unsigned SPRITE_NUM = 64,
  parameter int unsigned SLOT_NUM   = 8,
  parameter int unsigned POSY_BIT   = 10
);
  localparam int unsigned AW = (SPRITE_NUM > 1) ? $clog2(SPRITE_NUM) : 1;
  localparam int unsigned CW = $clog2(SLOT_NUM + 1);

  logic [POSY_BIT-1:0]     vgaPosY;
  logic                    IsGameWindow;
  logic [AW-1:0]           addrReadSpriteRam;
  logic [31:0]             dataFromSpriteRam;
  logic [32*SLOT_NUM-1:0]  slotData;
  logic [SLOT_NUM-1:0]     slotValid;
  logic [CW-1:0]           slotCount;
  logic                    spriteOverflow;
  logic                    scanBusy;
  logic                    scanDone;

  modport master (
    output vgaPosY, IsGameWindow, dataFromSpriteRam,
    input  addrReadSpriteRam, slotData, slotValid, slotCount,
    input  spriteOverflow, scanBusy, scanDone
  );

  modport slave (
    input  vgaPosY, IsGameWindow, dataFromSpriteRam,
    output addrReadSpriteRam, slotData, slotValid, slotCount,
    output spriteOverflow, scanBusy, scanDone
  );
endinterface

// File: rtl/sprite_line_eval.sv
// Per-scanline sprite evaluator: on game-window end, scans sprite RAM for sprites touching the next line.
// Optional macro LINE_SPRITE_DBUF_EN: slot outputs come from a shadow set committed on the window rise.
module sprite_line_eval #(
  parameter int unsigned SPRITE_NUM      = 64,
  parameter int unsigned SLOT_NUM        = 8,
  parameter int unsigned SPRITE_H        = 8,
  parameter int unsigned POSY_BIT        = 10,
  parameter int unsigned GAME_START_POSY = 0
) (
  input  logic              i_clkLineSprite,
  input  logic              i_rst,
  sprite_line_eval_if.slave bus
);
  localparam int unsigned AW = (SPRITE_NUM > 1) ? $clog2(SPRITE_NUM) : 1;
  localparam int unsigned CW = $clog2(SLOT_NUM + 1);
  localparam int unsigned HW = ((POSY_BIT > 9) ? POSY_BIT : 9) + 1;
  localparam int unsigned DW = 32 * SLOT_NUM;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_win_s1, r_win_s2, r_win_s3;
  logic                r_rise, r_fall;
  logic [POSY_BIT-1:0] r_next_line;
  logic [AW-1:0]       r_addr;
  logic [AW-1:0]       r_cmp_idx;
  logic                r_cmp_en;
  logic [DW-1:0]       r_work_data;
  logic [SLOT_NUM-1:0] r_work_valid;
  logic [CW-1:0]       r_work_count;
  logic                r_work_ovf;
  logic                r_busy, r_done;
  logic                w_busy_nxt, w_done_nxt;
  logic [HW-1:0]       w_y_lo, w_y_hi, w_line;
  logic                w_hit, w_full, w_ovf_hit, w_last_cmp;

  // Y range is widened so sprites near the bottom of the Y space never wrap.
  assign w_y_lo     = HW'(bus.dataFromSpriteRam[23:16]);
  assign w_y_hi     = w_y_lo + HW'(SPRITE_H);
  assign w_line     = HW'(r_next_line);
  assign w_hit      = r_cmp_en && (w_y_lo <= w_line) && (w_line < w_y_hi);
  assign w_full     = (r_work_count == CW'(SLOT_NUM));
  assign w_ovf_hit  = (r_state == S_SCAN) && w_hit && w_full;
  assign w_last_cmp = (r_state == S_SCAN) && r_cmp_en && (r_cmp_idx == AW'(SPRITE_NUM - 1));

  always_ff @(posedge i_clkLineSprite) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (r_fall) w_state_nxt = S_SCAN;
      S_SCAN: begin
        if (r_fall)                    w_state_nxt = S_SCAN;
        else if (r_rise || w_ovf_hit)  w_state_nxt = S_IDLE;
        else if (w_last_cmp)           w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = r_fall ? S_SCAN : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy_nxt = 1'b0;
    w_done_nxt = 1'b0;
    if (w_state_nxt == S_SCAN) w_busy_nxt = 1'b1;
    if (w_state_nxt == S_DONE) w_done_nxt = 1'b1;
  end

  // Window edge detect, address sequencing and work-slot fill.
  always_ff @(posedge i_clkLineSprite) begin
    if (i_rst) begin
      r_win_s1     <= 1'b0;
      r_win_s2     <= 1'b0;
      r_win_s3     <= 1'b0;
      r_rise       <= 1'b0;
      r_fall       <= 1'b0;
      r_next_line  <= '0;
      r_addr       <= '0;
      r_cmp_idx    <= '0;
      r_cmp_en     <= 1'b0;
      r_work_data  <= '0;
      r_work_valid <= '0;
      r_work_count <= '0;
      r_work_ovf   <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_win_s1 <= bus.IsGameWindow;
      r_win_s2 <= r_win_s1;
      r_win_s3 <= r_win_s2;
      r_rise   <= r_win_s2 & ~r_win_s3;
      r_fall   <= ~r_win_s2 & r_win_s3;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
      if (r_fall) begin
        r_next_line  <= POSY_BIT'(bus.vgaPosY - POSY_BIT'(GAME_START_POSY) + POSY_BIT'(1));
        r_addr       <= '0;
        r_cmp_idx    <= '0;
        r_cmp_en     <= 1'b0;
        r_work_data  <= '0;
        r_work_valid <= '0;
        r_work_count <= '0;
        r_work_ovf   <= 1'b0;
      end else if (r_state == S_SCAN && !r_rise) begin
        if (r_addr != AW'(SPRITE_NUM - 1)) r_addr <= r_addr + AW'(1);
        r_cmp_en <= 1'b1;
        if (r_cmp_en) r_cmp_idx <= r_cmp_idx + AW'(1);
        if (w_hit && !w_full) begin
          for (int k = 0; k < int'(SLOT_NUM); k++) begin
            if (r_work_count == CW'(k)) begin
              r_work_data[32*k +: 32] <= bus.dataFromSpriteRam;
              r_work_valid[k]         <= 1'b1;
            end
          end
          r_work_count <= r_work_count + CW'(1);
        end
        if (w_ovf_hit) r_work_ovf <= 1'b1;
      end
    end
  end

`ifdef LINE_SPRITE_DBUF_EN
  logic [DW-1:0]       r_out_data;
  logic [SLOT_NUM-1:0] r_out_valid;
  logic [CW-1:0]       r_out_count;
  logic                r_out_ovf;

  // Visible-line copy; whatever the shadow holds at the window rise is committed.
  always_ff @(posedge i_clkLineSprite) begin
    if (i_rst) begin
      r_out_data  <= '0;
      r_out_valid <= '0;
      r_out_count <= '0;
      r_out_ovf   <= 1'b0;
    end else if (r_rise) begin
      r_out_data  <= r_work_data;
      r_out_valid <= r_work_valid;
      r_out_count <= r_work_count;
      r_out_ovf   <= r_work_ovf;
    end
  end

  assign bus.slotData       = r_out_data;
  assign bus.slotValid      = r_out_valid;
  assign bus.slotCount      = r_out_count;
  assign bus.spriteOverflow = r_out_ovf;
`else
  assign bus.slotData       = r_work_data;
  assign bus.slotValid      = r_work_valid;
  assign bus.slotCount      = r_work_count;
  assign bus.spriteOverflow = r_work_ovf;
`endif

  assign bus.addrReadSpriteRam = r_addr;
  assign bus.scanBusy          = r_busy;
  assign bus.scanDone          = r_done;
endmodule
